// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment driver: hex decode, per-digit dp/blank, frame-aligned double buffering.
// Optional leading-zero suppression is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
   parameter int unsigned DIGITS         = 8,
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  load,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     dig_sel,
   output logic                  frame_tick
);

   localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DATA_W = 4 * DIGITS;

   localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

   logic [PRE_W-1:0]  pre;
   logic [IDX_W-1:0]  idx;
   logic              slot_end;
   logic              frame_end;
   logic              wrap_q;

   logic [DATA_W-1:0] pend_data, disp_data;
   logic [DIGITS-1:0] pend_dp, disp_dp;
   logic [DIGITS-1:0] pend_blank, disp_blank;
   logic              pend_v;

   logic [DIGITS-1:0] lz_blank;
   logic [3:0]        cur_nib;
   logic              cur_dp;
   logic              cur_blank;
   logic [DIGITS-1:0] sel_c;
   logic [6:0]        seg_c;
   logic              dp_c;
   logic [DIGITS-1:0] dig_c;

   // Active-high gfedcba pattern for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0:    hex7 = 7'b0111111;
         4'h1:    hex7 = 7'b0000110;
         4'h2:    hex7 = 7'b1011011;
         4'h3:    hex7 = 7'b1001111;
         4'h4:    hex7 = 7'b1100110;
         4'h5:    hex7 = 7'b1101101;
         4'h6:    hex7 = 7'b1111101;
         4'h7:    hex7 = 7'b0000111;
         4'h8:    hex7 = 7'b1111111;
         4'h9:    hex7 = 7'b1101111;
         4'hA:    hex7 = 7'b1110111;
         4'hB:    hex7 = 7'b1111100;
         4'hC:    hex7 = 7'b0111001;
         4'hD:    hex7 = 7'b1011110;
         4'hE:    hex7 = 7'b1111001;
         default: hex7 = 7'b1110001;
      endcase
   endfunction

   assign slot_end  = (pre == PRE_W'(SCAN_DIV - 1));
   assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));

   // Slot prescaler and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= slot_end ? '0 : pre + PRE_W'(1);
         if (slot_end) begin
            idx <= frame_end ? '0 : idx + IDX_W'(1);
         end
      end
   end

   // Pending/display buffers; a load in the boundary cycle bypasses pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         pend_v     <= 1'b0;
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
      end else if (frame_end) begin
         if (load) begin
            disp_data  <= data;
            disp_dp    <= dp_in;
            disp_blank <= blank_in;
         end else if (pend_v) begin
            disp_data  <= pend_data;
            disp_dp    <= pend_dp;
            disp_blank <= pend_blank;
         end
         pend_v <= 1'b0;
      end else if (load) begin
         pend_data  <= data;
         pend_dp    <= dp_in;
         pend_blank <= blank_in;
         pend_v     <= 1'b1;
      end
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic run;

   // Digit i>0 goes dark while every nibble from the top down to i is zero and its dp is off.
   always_comb begin
      lz_blank = '0;
      run      = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         run         = run && (disp_data[4*i +: 4] == 4'h0);
         lz_blank[i] = run && !disp_dp[i];
      end
   end
`else
   assign lz_blank = '0;
`endif

   // Select the current digit's content from the display register.
   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      sel_c     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_nib   = disp_data[4*i +: 4];
            cur_dp    = disp_dp[i];
            cur_blank = disp_blank[i] | lz_blank[i];
            sel_c[i]  = 1'b1;
         end
      end
   end

   assign seg_c = cur_blank ? SEG_OFF : (hex7(cur_nib) ^ {7{SEG_ACTIVE_LOW}});
   assign dp_c  = (cur_dp & ~cur_blank) ^ SEG_ACTIVE_LOW;
   assign dig_c = sel_c ^ {DIGITS{DIG_ACTIVE_LOW}};

   // Registered outputs; frame_tick trails the wrap by one edge to line up with digit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg        <= SEG_OFF;
         dp         <= DP_OFF;
         dig_sel    <= DIG_OFF;
         frame_tick <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         seg        <= seg_c;
         dp         <= dp_c;
         dig_sel    <= dig_c;
         frame_tick <= wrap_q;
         wrap_q     <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (4 digits, 4 clocks per slot, active-low).
module tb_seg_scan_driver;

   localparam int unsigned DIGITS   = 4;
   localparam int unsigned SCAN_DIV = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ_SEG = 7'h7F;
`else
   localparam logic [6:0] LZ_SEG = 7'h40;
`endif

   logic        clk;
   logic        rst;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dig_sel;
   logic        frame_tick;

   int n_tests;
   int n_fail;
   int cyc;

   seg_scan_driver #(
      .DIGITS        (DIGITS),
      .SCAN_DIV      (SCAN_DIV),
      .SEG_ACTIVE_LOW(1'b1),
      .DIG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data      (data),
      .dp_in     (dp_in),
      .blank_in  (blank_in),
      .load      (load),
      .seg       (seg),
      .dp        (dp),
      .dig_sel   (dig_sel),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go(input int e);
      while (cyc < e) tick();
   endtask

   // Digit shown after edge e (edges counted from 1 after reset release).
   function automatic logic [3:0] dig_exp(input int e);
      logic [3:0] one;
      int         sh;
      one = 4'b0001;
      sh  = ((e - 1) / 4) % 4;
      return ~(one << sh);
   endfunction

   function automatic logic ft_exp(input int e);
      return (e > 1) && ((e % 16) == 1);
   endfunction

   task automatic chk_out(input string tag, input logic [6:0] e_seg, input logic e_dp,
                          input logic [3:0] e_dig, input logic e_ft);
      n_tests++;
      assert (seg === e_seg) else begin
         n_fail++;
         $error("FAIL %s.seg cyc=%0d observed %h expected %h", tag, cyc, seg, e_seg);
      end
      n_tests++;
      assert (dp === e_dp) else begin
         n_fail++;
         $error("FAIL %s.dp cyc=%0d observed %b expected %b", tag, cyc, dp, e_dp);
      end
      n_tests++;
      assert (dig_sel === e_dig) else begin
         n_fail++;
         $error("FAIL %s.dig_sel cyc=%0d observed %b expected %b", tag, cyc, dig_sel, e_dig);
      end
      n_tests++;
      assert (frame_tick === e_ft) else begin
         n_fail++;
         $error("FAIL %s.frame_tick cyc=%0d observed %b expected %b", tag, cyc, frame_tick, e_ft);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      data     = 16'h0;
      dp_in    = 4'h0;
      blank_in = 4'h0;
      load     = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk_out("reset", 7'h7F, 1'b1, 4'hF, 1'b0);
      rst = 1'b0;
      cyc = 0;

      tick();
      chk_out("first_edge", 7'h40, 1'b1, 4'hE, 1'b0);

      // Scan sequence over two full frames plus
      for (int e = 2; e <= 36; e++) begin
         tick();
         chk_out("scan", 7'h40, 1'b1, dig_exp(cyc), ft_exp(cyc));
      end

      // Mid-frame load in the digit-1 slot
      go(37);
      data = 16'h12AF;
      load = 1'b1;
      tick();
      load = 1'b0;
      go(41); chk_out("old_keep2", 7'h40, 1'b1, dig_exp(cyc), 1'b0);
      go(48); chk_out("old_keep3", 7'h40, 1'b1, dig_exp(cyc), 1'b0);
      go(49); chk_out("mid_d0", 7'h0E, 1'b1, 4'hE, 1'b1);
      go(53); chk_out("mid_d1", 7'h08, 1'b1, 4'hD, 1'b0);
      go(57); chk_out("mid_d2", 7'h24, 1'b1, 4'hB, 1'b0);
      go(61); chk_out("mid_d3", 7'h79, 1'b1, 4'h7, 1'b0);

      // Two loads in one frame: last wins
      go(66);
      data = 16'h1111;
      load = 1'b1;
      tick();
      load = 1'b0;
      go(70);
      data = 16'h2222;
      load = 1'b1;
      tick();
      load = 1'b0;
      go(77); chk_out("dbl_old", 7'h79, 1'b1, 4'h7, 1'b0);
      go(81); chk_out("dbl_d0", 7'h24, 1'b1, 4'hE, 1'b1);
      go(85); chk_out("dbl_d1", 7'h24, 1'b1, 4'hD, 1'b0);
      go(89); chk_out("dbl_d2", 7'h24, 1'b1, 4'hB, 1'b0);
      go(93); chk_out("dbl_d3", 7'h24, 1'b1, 4'h7, 1'b0);

      // Load in the boundary cycle appears on the very next frame
      go(95);
      data = 16'h0045;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk_out("bnd_prev", 7'h24, 1'b1, 4'h7, 1'b0);
      go(97);  chk_out("bnd_d0", 7'h12, 1'b1, 4'hE, 1'b1);
      go(101); chk_out("bnd_d1", 7'h19, 1'b1, 4'hD, 1'b0);
      go(105); chk_out("lz_d2", LZ_SEG, 1'b1, 4'hB, 1'b0);
      go(109); chk_out("lz_d3", LZ_SEG, 1'b1, 4'h7, 1'b0);

      // Blank and decimal point
      go(114);
      data     = 16'h8765;
      dp_in    = 4'b0101;
      blank_in = 4'b0100;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      dp_in    = 4'h0;
      blank_in = 4'h0;
      go(129); chk_out("bd_d0", 7'h12, 1'b0, 4'hE, 1'b1);
      go(133); chk_out("bd_d1", 7'h02, 1'b1, 4'hD, 1'b0);
      go(137); chk_out("bd_d2", 7'h7F, 1'b1, 4'hB, 1'b0);
      go(141); chk_out("bd_d3", 7'h00, 1'b1, 4'h7, 1'b0);

      // All-zero data
      go(142);
      data = 16'h0000;
      load = 1'b1;
      tick();
      load = 1'b0;
      go(145); chk_out("zero_d0", 7'h40, 1'b1, 4'hE, 1'b1);
      go(149); chk_out("zero_d1", LZ_SEG, 1'b1, 4'hD, 1'b0);
      go(153); chk_out("zero_d2", LZ_SEG, 1'b1, 4'hB, 1'b0);
      go(157); chk_out("zero_d3", LZ_SEG, 1'b1, 4'h7, 1'b0);

      // Reset mid-frame discards pending data
      go(158);
      data = 16'hFFFF;
      load = 1'b1;
      tick();
      load = 1'b0;
      rst  = 1'b1;
      #1;
      chk_out("rst_mid", 7'h7F, 1'b1, 4'hF, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      tick();
      chk_out("rst_rel", 7'h40, 1'b1, 4'hE, 1'b0);
      go(17);
      chk_out("rst_discard", 7'h40, 1'b1, 4'hE, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment display driver: it decodes the full hex digit set (0-F), gives per-digit decimal point and blanking control, and scans `DIGITS` common-anode digits from one shared segment bus. New values are double-buffered and applied only at scan-frame boundaries, so the display never tears. It sits between the counter/clock datapath and the board display pins, and replaces per-digit static decoders.

## Interface
- `DIGITS`, 8: number of scanned digits (1-16).
- `SCAN_DIV`, 50000: clocks per digit slot (≥2).
- `SEG_ACTIVE_LOW`, 1: segment and dp outputs are active-low when 1.
- `DIG_ACTIVE_LOW`, 1: digit-select outputs are active-low when 1.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `data` in 4*DIGITS: nibble i = value of digit i; digit DIGITS-1 is most significant.
- `dp_in` in DIGITS: decimal point request per digit.
- `blank_in` in DIGITS: forces digit i dark (segments and dp off).
- `load` in 1: one-cycle strobe that captures `data`, `dp_in` and `blank_in`.
- `seg` out 7: segments {g,f,e,d,c,b,a}.
- `dp` out 1: decimal point.
- `dig_sel` out DIGITS: one-hot digit enable.
- `frame_tick` out 1: one-cycle pulse when the scan wraps to digit 0.

## Operation
- **Prescaler `pre`**: counts 0..SCAN_DIV-1 and wraps. The cycle with `pre`=SCAN_DIV-1 is the slot end.
- **Digit index `idx`**: advances at each slot end. It wraps DIGITS-1 → 0, and that wrap is the frame boundary.
- **Input buffering**:
  - `load` copies the inputs into a pending register and sets `pend_v`.
  - At a frame boundary with `pend_v` set, pending moves to the display register and `pend_v` clears.
  - Several loads within one frame: the last one wins.
  - `load` in the boundary cycle: the new inputs go straight to the display register and `pend_v` ends cleared.
- **Decode** (active-high form, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - With `SEG_ACTIVE_LOW`=1, `seg` and `dp` are inverted.
- **Blanked digit**: segments and dp inactive; `dig_sel` still strobes so brightness stays uniform.
- **Digit select**: exactly one `dig_sel` bit is active at any time outside reset.

## Timing
- **Reset values** (during `rst` and until the first rising edge after release):
  - `seg` and `dp` all inactive (0x7F / 1 when active-low).
  - `dig_sel` all inactive.
  - `frame_tick`=0.
  - `pre`=0, `idx`=0, display and pending registers 0, `pend_v`=0.
- **All outputs are registered.**
  - Edge k drives the outputs for the `idx` and display content present before edge k.
  - First edge after reset: digit 0 active, showing "0".
- **Slot length**: each digit is active for exactly SCAN_DIV cycles; a frame is DIGITS×SCAN_DIV cycles.
- **`seg`/`dig_sel` alignment**: both change on the same edge, with no skew cycle.
- **Load latency**: displayed data changes on the edge that starts the next frame (digit 0 slot).
- **`frame_tick`**: high for the single cycle in which `dig_sel` first selects digit 0 of a new frame; it is not asserted in the first frame after reset.
- **`rst` mid-frame**: immediately forces the reset values and discards pending data.

## Configuration
- **`SEG_LEADING_ZERO_BLANK_EN` defined**:
  - Digit i (i>0) is blanked when nibbles DIGITS-1..i of the display register are all zero and `dp_in[i]` is 0.
  - Digit 0 is never suppressed.
  - Blanking is computed from the display register only.
- **Macro undefined**: every digit shows its nibble and only `blank_in` blanks.

## Test plan
(DIGITS=4, SCAN_DIV=4, both polarities active-low.)
- **Reset**: during `rst`, `seg`=7'h7F, `dp`=1, `dig_sel`=4'hF. At the first edge after release, `dig_sel`=4'b1110 and `seg`=7'b100_0000.
- **Scan sequence**: `dig_sel` runs 1110, 1101, 1011, 0111, 1110, each held 4 cycles. `frame_tick` pulses every 16 cycles, coincident with 1110.
- **Mid-frame load**: `data`=16'h12AF loaded in the digit-1 slot. Old content stays until the next frame. Then digit0=7'b000_1110 (F), digit1=7'b000_1000 (A), digit2=7'b010_0100 (2), digit3=7'b111_1001 (1).
- **Double load / boundary load**:
  - Loading 16'h1111 then 16'h2222 in one frame shows only 2222.
  - A load in the boundary cycle shows on that frame with no extra delay.
- **Blank and dp**: `blank_in`=4'b0100 with `dp_in`=4'b0101. Digit 2 gives `seg`=7'h7F, `dp`=1. Digit 0 gives `dp`=0. `dig_sel` is still 1011 during digit 2.
- **Leading-zero macro**:
  - `data`=16'h0045 with the macro: digits 3 and 2 give `seg`=7'h7F, digit0=7'b001_0010.
  - Without the macro, digits 3 and 2 show 7'b100_0000.
  - `data`=0 with the macro: only digit 0 lit, showing "0".
